mem_arbiter: RTL and testbench

Parametrised N-requester memory arbiter that multiplexes the CPU's memory ports (instruction fetch, data access, and any future requesters such as a prefetcher or DMA) onto one shared memory interface. It generalises the fixed two-port arrangement of the pipeline top to `NUM_PORTS` requesters. It adds latched, one-at-a-time arbitration with selectable fixed or round-robin priority. It sits between the pipeline top and the single cache/memory controller.

---
 rtl/rv32i_types.sv | 17 +
 rtl/mem_arbiter_picker.sv | 32 +++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared CPU types: arbiter FSM state, arbiter port limit and the
// grant-index width helper.
package rv32i_types;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_MAX_PORTS = 8;

    // A single requester still needs a 1-bit index.
    function automatic int arb_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_picker.sv
// Combinational winner search. It starts at 'start', wraps modulo NUM_PORTS,
// and returns the first requesting index.
module arb_picker #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     start,
    output logic [IDX_W-1:0]     winner,
    output logic                 found
);

    int unsigned idx;

    // Scan from the farthest offset down so that the nearest requester is the last write.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = NUM_PORTS - 1; off >= 0; off--) begin
            idx = 32'(start) + 32'(off);
            if (idx >= 32'(NUM_PORTS)) begin
                idx = idx - 32'(NUM_PORTS);
            end
            if (|(req & (NUM_PORTS'(1) << idx))) begin
                winner = idx[IDX_W-1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-requester memory arbiter. It grants one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin priority; the default is fixed priority with the lowest index winning.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_PORTS-1:0]                    req_read,
    input  logic [NUM_PORTS-1:0]                    req_write,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]  req_wmask,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]    req_address,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_PORTS-1:0]                    req_resp,
    output logic [DATA_WIDTH-1:0]                   req_rdata,
    output logic                                    mem_read,
    output logic                                    mem_write,
    output logic [DATA_WIDTH/8-1:0]                 mem_wmask,
    output logic [ADDR_WIDTH-1:0]                   mem_address,
    output logic [DATA_WIDTH-1:0]                   mem_wdata,
    input  logic                                    mem_resp,
    input  logic [DATA_WIDTH-1:0]                   mem_rdata,
    output arb_state_e                              dbg_state
);

    localparam int IDX_W  = arb_idx_width(NUM_PORTS);
    localparam int MASK_W = DATA_WIDTH / 8;

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic [MASK_W-1:0]       mem_wmask_q, mem_wmask_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    logic [NUM_PORTS-1:0]    req_any;
    logic [IDX_W-1:0]        start;
    logic [IDX_W-1:0]        winner;
    logic                    found;

    assign req_any = req_read | req_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    // The search begins one past the last grant.
    assign start = (ptr_q == IDX_W'(NUM_PORTS - 1)) ? '0 : ptr_q + IDX_W'(1);
`else
    assign start = '0;
`endif

    arb_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req    (req_any),
        .start  (start),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_wmask_d   = mem_wmask_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d         = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = BUSY;
                    grant_d       = winner;
                    // A combined read+write request is issued as a write only.
                    mem_write_d   = req_write[winner];
                    mem_read_d    = req_read[winner] & ~req_write[winner];
                    mem_wmask_d   = req_wmask[winner];
                    mem_address_d = req_address[winner];
                    mem_wdata_d   = req_wdata[winner];
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d         = winner;
`endif
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    state_d       = IDLE;
                    mem_read_d    = 1'b0;
                    mem_write_d   = 1'b0;
                    mem_wmask_d   = '0;
                    mem_address_d = '0;
                    mem_wdata_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_wmask_q   <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q         <= IDX_W'(NUM_PORTS - 1);
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_wmask_q   <= mem_wmask_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q         <= ptr_d;
`endif
        end
    end

    // The completion path from memory back to the requester is combinational.
    always_comb begin
        req_resp = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_resp[i] = (state_q == BUSY) && mem_resp && (grant_q == IDX_W'(i));
        end
    end

    assign req_rdata   = mem_rdata;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_wmask   = mem_wmask_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, checked against a transaction-level model.
module tb_mem_arbiter;
    import rv32i_types::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N-1:0]           req_read, req_write;
    logic [N-1:0][MW-1:0]   req_wmask;
    logic [N-1:0][AW-1:0]   req_address;
    logic [N-1:0][DW-1:0]   req_wdata;
    logic [N-1:0]           req_resp;
    logic [DW-1:0]          req_rdata;
    logic                   mem_read, mem_write;
    logic [MW-1:0]          mem_wmask;
    logic [AW-1:0]          mem_address;
    logic [DW-1:0]          mem_wdata;
    logic                   mem_resp;
    logic [DW-1:0]          mem_rdata;
    arb_state_e             dbg_state;

    mem_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write), .req_wmask(req_wmask),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_resp(req_resp), .req_rdata(req_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding transaction, plus a queue of expected responding ports.
    bit             m_busy;
    int             m_grant, m_ptr;
    bit             m_rd, m_wr;
    logic [MW-1:0]  m_mask;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_wdata;
    logic [7:0]     exp_q[$];

    // Stimulus and observation state
    bit             rand_en, keep_en, mem_rand, record;
    int             mem_delay, wait_cnt;
    bit             seen_op;
    logic [N-1:0]   resp_seen;
    int             rd_hi_cnt, wr_hi_cnt;
    int             resp_cnt[N];
    int             obs_order[$];
    logic [DW-1:0]  last_rdata;
    logic [MW-1:0]  last_wmask;
    logic [AW-1:0]  last_waddr;

    function automatic int model_pick(input logic [N-1:0] reqs);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) if (reqs[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
        for (int i = 0; i < N; i++) if (reqs[i]) return i;
`endif
        return -1;
    endfunction

    task automatic clear_counts();
        rd_hi_cnt = 0;
        wr_hi_cnt = 0;
        foreach (resp_cnt[i]) resp_cnt[i] = 0;
        obs_order.delete();
    endtask

    task automatic new_req(input int i, input int op, input logic [AW-1:0] addr);
        req_read[i]    = (op != 1);
        req_write[i]   = (op != 0);
        req_address[i] = addr;
        req_wdata[i]   = $urandom;
        req_wmask[i]   = MW'($urandom);
    endtask

    // Runs at the falling edge: compare the DUT against the model, then advance the model past the next rising edge.
    task automatic model_check();
        logic [N-1:0] exp_resp;
        int p, e, w;
        exp_resp = '0;
        check_eq("state", dbg_state, m_busy ? BUSY : IDLE);
        check_eq("mem_read", mem_read, m_busy & m_rd);
        check_eq("mem_write", mem_write, m_busy & m_wr);
        if (m_busy) begin
            check_eq("mem_address", mem_address, m_addr);
            check_eq("mem_wmask", mem_wmask, m_mask);
            check_eq("mem_wdata", mem_wdata, m_wdata);
            if (mem_resp) exp_resp[m_grant] = 1'b1;
        end
        check_eq("req_resp", req_resp, exp_resp);
        check_eq("req_rdata", req_rdata, mem_rdata);
        if (req_resp != '0) begin
            p = -1;
            for (int i = 0; i < N; i++) if (req_resp[i]) p = i;
            if (exp_q.size() == 0) begin
                check_eq("resp_unexpected", req_resp, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("resp_port", req_resp, 64'(1) << e);
            end
            if (record) obs_order.push_back(p);
            if (p >= 0) resp_cnt[p]++;
            last_rdata = req_rdata;
        end
        if (mem_read) rd_hi_cnt++;
        if (mem_write) begin
            wr_hi_cnt++;
            last_wmask = mem_wmask;
            last_waddr = mem_address;
        end
        seen_op   = mem_read | mem_write;
        resp_seen = req_resp;
        if (!m_busy) begin
            w = model_pick(req_read | req_write);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_grant = w;
                m_wr    = req_write[w];
                m_rd    = req_read[w] & ~req_write[w];
                m_mask  = req_wmask[w];
                m_addr  = req_address[w];
                m_wdata = req_wdata[w];
                m_ptr   = w;
                exp_q.push_back(8'(w));
            end
        end else if (mem_resp) begin
            m_busy = 1'b0;
        end
    endtask

    // Runs just after the rising edge: drive the memory model and the requesters.
    task automatic drive_next();
        if (mem_resp) begin
            mem_resp = 1'b0;
            wait_cnt = 0;
            if (mem_rand) mem_delay = $urandom_range(0, 3);
        end else if (seen_op) begin
            if (wait_cnt >= mem_delay) mem_resp = 1'b1;
            else wait_cnt++;
        end else if (mem_rand && $urandom_range(0, 7) == 0) begin
            mem_resp = 1'b1;
        end
        mem_rdata = mem_rand ? DW'($urandom) : 32'hDEAD_BEEF;
        for (int i = 0; i < N; i++) begin
            if (resp_seen[i]) begin
                req_read[i]  = 1'b0;
                req_write[i] = 1'b0;
            end else if (!(req_read[i] | req_write[i])) begin
                if (keep_en) new_req(i, 0, AW'(32'h6000 + 32'(i) * 4));
                else if (rand_en && $urandom_range(0, 3) == 0)
                    new_req(i, int'($urandom_range(0, 2)), AW'($urandom));
            end else if (rand_en && $urandom_range(0, 31) == 0) begin
                req_read[i]  = 1'b0;
                req_write[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        drive_next();
    endtask

    int exp_order[5];

    initial begin
        reset = 1'b1;
        req_read = '0; req_write = '0; req_wmask = '0; req_address = '0; req_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        m_busy = 1'b0; m_grant = 0; m_ptr = N - 1; m_rd = 0; m_wr = 0;
        m_mask = '0; m_addr = '0; m_wdata = '0;
        rand_en = 0; keep_en = 0; mem_rand = 0; record = 0;
        mem_delay = 1; wait_cnt = 0; seen_op = 0; resp_seen = '0;
        last_rdata = '0; last_wmask = '0; last_waddr = '0;
        clear_counts();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_state", dbg_state, IDLE);
        check_eq("rst_mem_read", mem_read, 0);
        check_eq("rst_mem_write", mem_write, 0);
        check_eq("rst_mem_address", mem_address, 0);
        check_eq("rst_req_resp", req_resp, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single read from port 1 with a three-cycle memory
        mem_delay = 1;
        mem_rdata = 32'hDEAD_BEEF;
        new_req(1, 0, 32'h0000_1000);
        clear_counts();
        for (int k = 0; k < 20 && resp_cnt[1] == 0; k++) step();
        step(); step();
        check_eq("single_rd_cycles", rd_hi_cnt, 3);
        check_eq("single_rd_resp", resp_cnt[1], 1);
        check_eq("single_rd_data", last_rdata, 32'hDEAD_BEEF);

        // Port 0 read and port 1 write arrive at the same edge
        clear_counts();
        record = 1;
        new_req(0, 0, 32'h100);
        new_req(1, 1, 32'h200);
        req_wmask[1] = 4'b0011;
        for (int k = 0; k < 40 && obs_order.size() < 2; k++) step();
        step();
        record = 0;
        check_eq("simul_count", obs_order.size(), 2);
        if (obs_order.size() >= 2) begin
            check_eq("simul_first", obs_order[0], 0);
            check_eq("simul_second", obs_order[1], 1);
        end
        check_eq("simul_wmask", last_wmask, 4'b0011);
        check_eq("simul_waddr", last_waddr, 32'h200);

        // Port 0 withdraws its read one cycle into BUSY
        clear_counts();
        mem_delay = 2;
        new_req(0, 0, 32'h300);
        step(); step();
        req_read[0] = 1'b0;
        for (int k = 0; k < 20 && resp_cnt[0] == 0; k++) step();
        step(); step();
        check_eq("withdraw_resp", resp_cnt[0], 1);
        check_eq("withdraw_rd_cycles", rd_hi_cnt, 4);

        // Read and write together on port 0 issue a write only
        clear_counts();
        mem_delay = 0;
        new_req(0, 2, 32'h400);
        for (int k = 0; k < 20 && resp_cnt[0] == 0; k++) step();
        step();
        check_eq("rw_no_read", rd_hi_cnt, 0);
        check_eq("rw_wr_cycles", wr_hi_cnt, 2);
        check_eq("rw_resp", resp_cnt[0], 1);

        // Randomized traffic, including spurious idle responses and withdrawals
        rand_en = 1; mem_rand = 1;
        for (int k = 0; k < 1500; k++) step();
        rand_en = 0;
        for (int k = 0; k < 200 && (m_busy || (req_read | req_write) != '0); k++) step();
        step(); step();
        check_eq("sb_drain", exp_q.size(), 0);

        // Reset in the middle of a transaction, followed by a late response
        mem_rand = 0; mem_delay = 3;
        new_req(2, 0, 32'h500);
        for (int k = 0; k < 10 && !m_busy; k++) step();
        step();
        @(negedge clk);
        #1;
        reset = 1'b1;
        mem_resp = 1'b1;
        #1;
        check_eq("midrst_mem_read", mem_read, 0);
        check_eq("midrst_mem_write", mem_write, 0);
        check_eq("midrst_req_resp", req_resp, 0);
        check_eq("midrst_state", dbg_state, IDLE);
        m_busy = 1'b0; m_ptr = N - 1; exp_q.delete();
        resp_seen = '0; seen_op = 0; wait_cnt = 0; mem_delay = 1;
        clear_counts();
        record = 1; keep_en = 1;
        for (int i = 0; i < N; i++) new_req(i, 0, AW'(32'h6000 + 32'(i) * 4));
        @(posedge clk);
        #1 reset = 1'b0;

        // All ports then request continuously, starting from reset priority
        for (int k = 0; k < 60 && obs_order.size() < 5; k++) step();
        keep_en = 0; record = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 1, 0, 1, 0};
`endif
        check_eq("order_count", obs_order.size() >= 5, 1);
        for (int k = 0; k < 5 && k < obs_order.size(); k++)
            check_eq($sformatf("order_%0d", k), obs_order[k], exp_order[k]);
        for (int k = 0; k < 40 && (m_busy || (req_read | req_write) != '0); k++) step();
        check_eq("final_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
